mycpu_pipe_ctrl: RTL

//  Central pipeline sequencer for the 5-stage core (IF/ID/EX/MEM/WB). Keeps per-stage valid

---
 rtl/mycpu_pkg.sv | 34 +++
 rtl/mycpu_stage_slot.sv | 32 +++
 rtl/mycpu_pipe_ctrl.sv | 133 +++++++++++++
 3 files changed

// File: rtl/mycpu_pkg.sv
// Shared types and tag helpers for the pipeline sequencer.
package mycpu_pkg;

    localparam int unsigned TAG_W        = 6;
    localparam int unsigned REG_W        = 5;
    localparam int unsigned TAG_LOAD_BIT = 5;
    localparam int unsigned TAG_REG_MSB  = 4;

    localparam logic [TAG_W-1:0] TAG_NONE = '0;

    typedef struct packed {
        logic             wen;
        logic [REG_W-1:0] dest;
        logic             is_load;
        logic             is_mem;
    } stage_info_t;

    localparam stage_info_t STAGE_EMPTY = '0;

    // Hazard tag: {load_pending, dest}, zero for bubbles, non-writers and $0.
    function automatic logic [TAG_W-1:0] make_tag(input logic             valid,
                                                  input logic             wen,
                                                  input logic             is_load,
                                                  input logic [REG_W-1:0] dest);
        logic [TAG_W-1:0] tag;
        tag = TAG_NONE;
        if (valid && wen && (dest != '0)) begin
            tag[TAG_LOAD_BIT]    = is_load;
            tag[TAG_REG_MSB:0]   = dest;
        end
        return tag;
    endfunction

endpackage

// File: rtl/mycpu_stage_slot.sv
// One pipeline stage's bookkeeping: valid bit plus destination/type payload.
module mycpu_stage_slot
    import mycpu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        bubble,
    input  logic        squash,
    input  stage_info_t d,
    output logic        valid,
    output stage_info_t q
);

    // Squash wins over a load; payload only moves with a real instruction.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            q     <= STAGE_EMPTY;
        end else begin
            if (squash) begin
                valid <= 1'b0;
            end else if (load) begin
                valid <= ~bubble;
            end
            if (load && !bubble) begin
                q <= d;
            end
        end
    end

endmodule

// File: rtl/mycpu_pipe_ctrl.sv
// Five-stage pipeline sequencer: valids, hazard tags, stage enables, stall counter.
module mycpu_pipe_ctrl
    import mycpu_pkg::*;
#(
    parameter int unsigned STALL_CNT_W = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   if_valid,
    input  logic                   id_allow_in,
    input  logic                   id_wen,
    input  logic [REG_W-1:0]       id_dest,
    input  logic                   id_is_load,
    input  logic                   id_is_mem,
    input  logic                   mem_data_ok,
    input  logic                   flush,
    output logic                   pc_en,
    output logic                   ifid_en,
    output logic                   idex_en,
    output logic                   exmem_en,
    output logic                   memwb_en,
    output logic                   id_valid,
    output logic                   ex_valid,
    output logic                   mem_valid,
    output logic                   wb_valid,
    output logic [TAG_W-1:0]       tag_m1,
    output logic [TAG_W-1:0]       tag_m2,
    output logic [TAG_W-1:0]       tag_m3,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    localparam logic [STALL_CNT_W-1:0] CNT_MAX = '1;

    stage_info_t id_in;
    stage_info_t id_info;
    stage_info_t ex_info;
    stage_info_t mem_info;
    stage_info_t wb_info;
    logic        mem_done;
    logic        mem_go;
    logic        mem_allow;
    logic        ex_allow;
    logic        id_go;
    logic        id_allow;
    logic        unused_ok;

    assign id_in = '{wen: id_wen, dest: id_dest, is_load: id_is_load, is_mem: id_is_mem};

    // Allow-in chain from WB (always accepting) back to ID.
    assign mem_go    = ~mem_info.is_mem | mem_done | mem_data_ok;
    assign mem_allow = ~mem_valid | mem_go;
    assign ex_allow  = ~ex_valid | mem_allow;
    assign id_go     = id_valid & id_allow_in & ex_allow;
    assign id_allow  = ~id_valid | id_go;

    assign pc_en    = id_allow | flush;
    assign ifid_en  = id_allow;
    assign idex_en  = ex_allow;
    assign exmem_en = mem_allow;
    assign memwb_en = mem_valid & mem_go;

    mycpu_stage_slot u_id_slot (
        .clk    (clk),
        .rst    (rst),
        .load   (id_allow),
        .bubble (~if_valid),
        .squash (flush),
        .d      (STAGE_EMPTY),
        .valid  (id_valid),
        .q      (id_info)
    );

    mycpu_stage_slot u_ex_slot (
        .clk    (clk),
        .rst    (rst),
        .load   (ex_allow),
        .bubble (~id_go),
        .squash (flush),
        .d      (id_in),
        .valid  (ex_valid),
        .q      (ex_info)
    );

    // A flushed EX instruction never reaches MEM.
    mycpu_stage_slot u_mem_slot (
        .clk    (clk),
        .rst    (rst),
        .load   (mem_allow),
        .bubble (~ex_valid | flush),
        .squash (1'b0),
        .d      (ex_info),
        .valid  (mem_valid),
        .q      (mem_info)
    );

    mycpu_stage_slot u_wb_slot (
        .clk    (clk),
        .rst    (rst),
        .load   (1'b1),
        .bubble (~memwb_en),
        .squash (1'b0),
        .d      (mem_info),
        .valid  (wb_valid),
        .q      (wb_info)
    );

    assign unused_ok = ^{id_info, wb_info.is_load, wb_info.is_mem};

    // Sticky data-memory completion for the MEM instruction.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_done <= 1'b0;
        end else if (memwb_en) begin
            mem_done <= 1'b0;
        end else if (mem_valid && mem_info.is_mem && mem_data_ok) begin
            mem_done <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (id_valid && !id_go && !flush && (stall_cnt != CNT_MAX)) begin
            stall_cnt <= stall_cnt + STALL_CNT_W'(1);
        end
    end

    assign tag_m1 = make_tag(ex_valid, ex_info.wen, ex_info.is_load, ex_info.dest);
    assign tag_m2 = make_tag(mem_valid, mem_info.wen,
                             mem_info.is_load & ~mem_done & ~mem_data_ok, mem_info.dest);
    assign tag_m3 = make_tag(wb_valid, wb_info.wen, 1'b0, wb_info.dest);

endmodule
